// File: rtl/ocm_port_arbiter_if.sv
// ocm_port_arbiter_if: requester A/B command handshakes and the OCM s2 port bundle.
interface ocm_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_write;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  modport slave (
    input  a_req, a_write, a_addr, a_wdata, b_req, b_write, b_addr, b_wdata, mem_readdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata
  );
  modport master (
    output a_req, a_write, a_addr, a_wdata, b_req, b_write, b_addr, b_wdata, mem_readdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata
  );
endinterface

// File: rtl/ocm_port_arbiter.sv
// ocm_port_arbiter: shares the OCM s2 port between zoom engine (A) and scan-out (B), tagging read returns.
// Define ARB_FIXED_PRIO_EN to make B win every conflict instead of round-robin.
module ocm_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input logic               clk_clk,
  input logic               reset_reset_n,
  input logic               sync_clr,
  ocm_port_arbiter_if.slave bus
);
  logic                    w_ok;
  logic                    w_a_gnt;
  logic                    w_b_gnt;
  logic                    r_cs;
  logic                    r_wr;
  logic                    r_own;
  logic                    r_clken;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_vown;
  assign w_ok = reset_reset_n & ~sync_clr;
`ifdef ARB_FIXED_PRIO_EN
  assign w_a_gnt = w_ok & bus.a_req & ~bus.b_req;
`else
  localparam logic OWN_B = 1'b1;
  logic r_last_owner;
  assign w_a_gnt = w_ok & bus.a_req & (~bus.b_req | (r_last_owner == OWN_B));
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_last_owner <= OWN_B;
    else if (sync_clr) r_last_owner <= OWN_B;
    else if (w_a_gnt | w_b_gnt) r_last_owner <= w_b_gnt;
  end
`endif
  assign w_b_gnt = w_ok & bus.b_req & ~w_a_gnt;
  // r_vld/r_vown track reads already on the port; the tail lines up with mem_readdata
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_own   <= 1'b0;
      r_clken <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_vld   <= '0;
      r_vown  <= '0;
    end else begin
      r_clken <= 1'b1;
      r_cs    <= w_a_gnt | w_b_gnt;
      r_wr    <= w_a_gnt ? bus.a_write : (w_b_gnt & bus.b_write);
      if (w_a_gnt | w_b_gnt) begin
        r_addr  <= w_a_gnt ? bus.a_addr : bus.b_addr;
        r_wdata <= w_a_gnt ? bus.a_wdata : bus.b_wdata;
        r_own   <= w_b_gnt;
      end
      r_vld[0]  <= ~sync_clr & r_cs & ~r_wr;
      r_vown[0] <= r_own;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i]  <= ~sync_clr & r_vld[i-1];
        r_vown[i] <= r_vown[i-1];
      end
    end
  end
  assign bus.a_gnt          = w_a_gnt;
  assign bus.b_gnt          = w_b_gnt;
  assign bus.a_rvalid       = ~sync_clr & r_vld[READ_LATENCY-1] & ~r_vown[READ_LATENCY-1];
  assign bus.b_rvalid       = ~sync_clr & r_vld[READ_LATENCY-1] & r_vown[READ_LATENCY-1];
  assign bus.a_rdata        = bus.mem_readdata;
  assign bus.b_rdata        = bus.mem_readdata;
  assign bus.mem_address    = r_addr;
  assign bus.mem_chipselect = r_cs;
  assign bus.mem_clken      = r_clken & ~sync_clr;
  assign bus.mem_write      = r_wr;
  assign bus.mem_writedata  = r_wdata;
endmodule

// File: tb/tb_ocm_port_arbiter.sv
// tb_ocm_port_arbiter: directed bench for the OCM arbiter with latency-1 and latency-3 instances.
module tb_ocm_port_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [0:32767];
  logic [7:0] rd = 8'h00;
  ocm_port_arbiter_if #(.ADDR_W(15), .DATA_W(8)) if1 ();
  ocm_port_arbiter_if #(.ADDR_W(15), .DATA_W(8)) if3 ();
  ocm_port_arbiter #(.ADDR_W(15), .DATA_W(8), .READ_LATENCY(1)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .sync_clr(sync_clr), .bus(if1)
  );
  ocm_port_arbiter #(.ADDR_W(15), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
    .clk_clk(clk), .reset_reset_n(rst_n), .sync_clr(sync_clr), .bus(if3)
  );
  always #5 clk = ~clk;
  // latency-1 memory model driven by the latency-1 instance's port
  always @(posedge clk) begin
    if (if1.mem_chipselect) begin
      if (if1.mem_write) mem[if1.mem_address] <= if1.mem_writedata;
      else rd <= mem[if1.mem_address];
    end
  end
  assign if1.mem_readdata = rd;
  assign if3.mem_readdata = rd;
  assign if3.a_req   = if1.a_req;
  assign if3.a_write = if1.a_write;
  assign if3.a_addr  = if1.a_addr;
  assign if3.a_wdata = if1.a_wdata;
  assign if3.b_req   = if1.b_req;
  assign if3.b_write = if1.b_write;
  assign if3.b_addr  = if1.b_addr;
  assign if3.b_wdata = if1.b_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  initial begin
    if1.a_req = 0; if1.a_write = 0; if1.a_addr = '0; if1.a_wdata = '0;
    if1.b_req = 0; if1.b_write = 0; if1.b_addr = '0; if1.b_wdata = '0;
    #2;
    chk("rst_cs", if1.mem_chipselect, 1'b0);
    chk("rst_clken", if1.mem_clken, 1'b0);
    chk("rst_write", if1.mem_write, 1'b0);
    chk("rst_addr", if1.mem_address, 15'h0);
    chk("rst_wdata", if1.mem_writedata, 8'h0);
    chk("rst_gnt", {if1.a_gnt, if1.b_gnt}, 2'b00);
    chk("rst_rvalid", {if1.a_rvalid, if1.b_rvalid}, 2'b00);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1 chk("clken_before_edge", if1.mem_clken, 1'b0);
    next();
    #1 chk("clken_after_release", if1.mem_clken, 1'b1);
    chk("idle_cs", if1.mem_chipselect, 1'b0);
    // A writes 0x5A to 0x0123, then reads it back
    if1.a_req = 1; if1.a_write = 1; if1.a_addr = 15'h0123; if1.a_wdata = 8'h5A;
    #1 chk("wr_a_gnt", if1.a_gnt, 1'b1);
    chk("wr_b_gnt", if1.b_gnt, 1'b0);
    next();
    if1.a_write = 0;
    #1 chk("rd_a_gnt", if1.a_gnt, 1'b1);
    chk("wr_cs", if1.mem_chipselect, 1'b1);
    chk("wr_mem_write", if1.mem_write, 1'b1);
    chk("wr_addr", if1.mem_address, 15'h0123);
    chk("wr_wdata", if1.mem_writedata, 8'h5A);
    next();
    if1.a_req = 0;
    #1 chk("rd_mem_write", if1.mem_write, 1'b0);
    chk("rd_cs", if1.mem_chipselect, 1'b1);
    chk("rd_rvalid_early", if1.a_rvalid, 1'b0);
    next();
    #1 chk("rd_a_rvalid", if1.a_rvalid, 1'b1);
    chk("rd_a_rdata", if1.a_rdata, 8'h5A);
    chk("rd_b_rvalid", if1.b_rvalid, 1'b0);
    next();
    #1 chk("rd_rvalid_pulse", if1.a_rvalid, 1'b0);
    // B writes 0x33 to 0x0200, leaving last_owner = B
    if1.b_req = 1; if1.b_write = 1; if1.b_addr = 15'h0200; if1.b_wdata = 8'h33;
    #1 chk("bwr_gnt", {if1.a_gnt, if1.b_gnt}, 2'b01);
    next();
    if1.b_write = 0; if1.a_write = 0;
    // continuous dual reads for six cycles, then two drain cycles
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next();
      if1.a_req = (k < 6);
      if1.b_req = (k < 6);
      #1;
      chk($sformatf("dual_a_gnt_%0d", k), if1.a_gnt, (k < 6) && !FIXED && (k % 2 == 0));
      chk($sformatf("dual_b_gnt_%0d", k), if1.b_gnt, (k < 6) && (FIXED || (k % 2 == 1)));
      chk($sformatf("dual_one_gnt_%0d", k), if1.a_gnt & if1.b_gnt, 1'b0);
      chk($sformatf("dual_a_rv_%0d", k), if1.a_rvalid, (k >= 2) && !FIXED && (k % 2 == 0));
      chk($sformatf("dual_b_rv_%0d", k), if1.b_rvalid, (k >= 2) && (FIXED || (k % 2 == 1)));
      if (k >= 2) chk($sformatf("dual_rdata_%0d", k), if1.a_rdata, (FIXED || (k % 2 == 1)) ? 8'h33 : 8'h5A);
    end
    // sync_clr with reads in flight
    next();
    if1.a_req = 1; if1.b_req = 1;
    #1 chk("clr_c0_gnt", {if1.a_gnt, if1.b_gnt}, FIXED ? 2'b01 : 2'b10);
    next();
    if1.a_req = FIXED; if1.b_req = !FIXED; sync_clr = 1;
    #1 chk("clr_c1_gnt", {if1.a_gnt, if1.b_gnt}, 2'b00);
    chk("clr_c1_clken", if1.mem_clken, 1'b0);
    chk("clr_c1_rv3", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    chk("clr_c1_rv1", {if1.a_rvalid, if1.b_rvalid}, 2'b00);
    next();
    sync_clr = 0; if1.a_req = 1; if1.b_req = 1;
    #1 chk("clr_c2_cs3", if3.mem_chipselect, 1'b0);
    chk("clr_c2_cs1", if1.mem_chipselect, 1'b0);
    chk("clr_c2_rv1", {if1.a_rvalid, if1.b_rvalid}, 2'b00);
    chk("clr_c2_rv3", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    chk("clr_c2_gnt", {if1.a_gnt, if1.b_gnt}, FIXED ? 2'b01 : 2'b10);
    next();
    if1.b_req = 0;
    #1 chk("clr_c3_gnt", {if1.a_gnt, if1.b_gnt}, 2'b10);
    chk("clr_c3_rv3", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    chk("clr_c3_rv1", {if1.a_rvalid, if1.b_rvalid}, 2'b00);
    next();
    if1.a_req = 0;
    #1 chk("clr_c4_rv3", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    chk("clr_c4_rv1", {if1.a_rvalid, if1.b_rvalid}, FIXED ? 2'b01 : 2'b10);
    next();
    #1 chk("clr_c5_rv3", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    next();
    #1 chk("lat3_c6_rv", {if3.a_rvalid, if3.b_rvalid}, FIXED ? 2'b01 : 2'b10);
    next();
    #1 chk("lat3_c7_rv", {if3.a_rvalid, if3.b_rvalid}, 2'b10);
    next();
    #1 chk("lat3_c8_rv", {if3.a_rvalid, if3.b_rvalid}, 2'b00);
    // asynchronous reset while a command is on the port
    if1.a_req = 1; if1.a_addr = 15'h0123;
    #1 chk("ar_gnt", if1.a_gnt, 1'b1);
    next();
    #1 chk("ar_cs_before", if1.mem_chipselect, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("ar_cs", if1.mem_chipselect, 1'b0);
    chk("ar_cs3", if3.mem_chipselect, 1'b0);
    chk("ar_clken", if1.mem_clken, 1'b0);
    chk("ar_addr", if1.mem_address, 15'h0);
    chk("ar_write", if1.mem_write, 1'b0);
    chk("ar_gnt_low", {if1.a_gnt, if1.b_gnt}, 2'b00);
    chk("ar_rvalid", {if1.a_rvalid, if1.b_rvalid}, 2'b00);
    if1.a_req = 0;
    next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
